// File: rtl/uart_rx.sv
// 8N1 UART receiver, LSB first, sampled on an external oversample tick.
// Emits a one-clk rx_done with the byte, or a one-clk frame_err if the stop bit is low.
module uart_rx #(
   parameter int unsigned OVERSAMPLE = 16
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       tick_i,
   input  logic       rx_i,
   output logic [7:0] rx_data_o,
   output logic       rx_done_o,
   output logic       frame_err_o,
   output logic       rx_busy_o
);

   localparam int unsigned TickW = $clog2(OVERSAMPLE);
   localparam logic [TickW-1:0] MidTick  = TickW'(OVERSAMPLE / 2 - 1);
   localparam logic [TickW-1:0] LastTick = TickW'(OVERSAMPLE - 1);

   typedef enum logic [2:0] {
      StIdle,
      StStart,
      StData,
      StStop,
      StWaitHigh
   } state_e;

   state_e           state_q;
   logic             rx_meta_q;
   logic             rx_s_q;
   logic [TickW-1:0] tick_cnt_q;
   logic [2:0]       bit_cnt_q;
   logic [7:0]       shift_q;
   logic [7:0]       rx_data_q;
   logic             rx_done_q;
   logic             frame_err_q;
   logic             rx_busy_q;

   // Both stages reset high so reset release never looks like a start bit.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rx_meta_q <= 1'b1;
         rx_s_q    <= 1'b1;
      end else begin
         rx_meta_q <= rx_i;
         rx_s_q    <= rx_meta_q;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= StIdle;
         tick_cnt_q  <= '0;
         bit_cnt_q   <= '0;
         shift_q     <= '0;
         rx_data_q   <= '0;
         rx_done_q   <= 1'b0;
         frame_err_q <= 1'b0;
         rx_busy_q   <= 1'b0;
      end else begin
         rx_done_q   <= 1'b0;
         frame_err_q <= 1'b0;
         case (state_q)
            StIdle: begin
               if (!rx_s_q) begin
                  state_q    <= StStart;
                  tick_cnt_q <= '0;
                  rx_busy_q  <= 1'b1;
               end
            end
            StStart: begin
               if (tick_i) begin
                  if (tick_cnt_q == MidTick) begin
                     tick_cnt_q <= '0;
                     if (!rx_s_q) begin
                        state_q   <= StData;
                        bit_cnt_q <= '0;
                     end else begin
                        // Line went back high before mid start bit: treat as noise.
                        state_q   <= StIdle;
                        rx_busy_q <= 1'b0;
                     end
                  end else begin
                     tick_cnt_q <= tick_cnt_q + 1'b1;
                  end
               end
            end
            StData: begin
               if (tick_i) begin
                  if (tick_cnt_q == LastTick) begin
                     tick_cnt_q <= '0;
                     shift_q    <= {rx_s_q, shift_q[7:1]};
                     if (bit_cnt_q == 3'd7) begin
                        state_q <= StStop;
                     end else begin
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                     end
                  end else begin
                     tick_cnt_q <= tick_cnt_q + 1'b1;
                  end
               end
            end
            StStop: begin
               if (tick_i) begin
                  if (tick_cnt_q == LastTick) begin
                     tick_cnt_q <= '0;
                     if (rx_s_q) begin
                        rx_data_q <= shift_q;
                        rx_done_q <= 1'b1;
                        state_q   <= StIdle;
                        rx_busy_q <= 1'b0;
                     end else begin
                        frame_err_q <= 1'b1;
                        state_q     <= StWaitHigh;
                     end
                  end else begin
                     tick_cnt_q <= tick_cnt_q + 1'b1;
                  end
               end
            end
            StWaitHigh: begin
               // A held-low (break) line must not start a new frame.
               if (rx_s_q) begin
                  state_q   <= StIdle;
                  rx_busy_q <= 1'b0;
               end
            end
            default: begin
               state_q   <= StIdle;
               rx_busy_q <= 1'b0;
            end
         endcase
      end
   end

   assign rx_data_o   = rx_data_q;
   assign rx_done_o   = rx_done_q;
   assign frame_err_o = frame_err_q;
   assign rx_busy_o   = rx_busy_q;

endmodule
